psram_burst_scheduler: RTL and testbench

PSRAM_BURST_SCHEDULER -- requirements
Module: psram_burst_scheduler

---
 rtl/psram_burst_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_psram_burst_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_burst_scheduler.sv
// psram_burst_scheduler
//   Arbitrates PSRAM burst slots between a camera writer and a VGA reader.
//   Camera and VGA frames each live in one of two banks. The camera fills one
//   bank while the VGA reads the bank the camera finished most recently.
//   One burst runs at a time: IDLE -> ISSUE (go pulse) -> BUSY -> IDLE.
// Ports
//   clk        burst clock
//   rst        asynchronous active-high reset
//   cam_req    camera FIFO nearly full: a write burst is wanted
//   vga_req    VGA FIFO nearly empty: a read burst is wanted
//   cam_sof    camera start-of-frame pulse, rewinds the camera pointer
//   done       burst-complete pulse from the PSRAM controller
//   go         one-cycle burst start
//   wr         1 = camera write burst, 0 = VGA read burst
//   brst_addr  burst start word address
//   vga_rst    holds VGA timing in reset until the display pipe is primed
//   cam_bank   bank being written by the camera
//   vga_bank   bank being read by the VGA
//   err        sticky burst-timeout flag
module psram_burst_scheduler #(
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter logic [22:0] BANK1_BASE  = 23'h080000,
  parameter int unsigned STREAK_MAX  = 4,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cam_req,
  input  logic        vga_req,
  input  logic        cam_sof,
  input  logic        done,
  output logic        go,
  output logic        wr,
  output logic [22:0] brst_addr,
  output logic        vga_rst,
  output logic        cam_bank,
  output logic        vga_bank,
  output logic        err
);

  localparam int unsigned SW = $clog2(STREAK_MAX + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [19:0]   PTR_STEP   = 20'(BURST_LEN);
  localparam logic [19:0]   FRAME_END  = 20'(FRAME_WORDS);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_cam_req_q;
  logic          r_vga_req_q;
  logic          r_wr;
  logic [22:0]   r_addr;
  logic          r_cam_bank;
  logic          r_vga_bank;
  logic          r_done_bank;
  logic [18:0]   r_cam_ptr;
  logic [18:0]   r_vga_ptr;
  logic          r_frame_valid;
  logic [SW-1:0] r_streak;
  logic          r_err;
  logic          r_vga_rst;
  logic          r_sof_pend;
  logic [TW-1:0] r_tmo_cnt;

  logic          w_go;
  logic          w_vga_elig;
  logic          w_cam_win;
  logic          w_grant;
  logic          w_tmo;
  logic          w_burst_end;
  logic          w_cam_active;
  logic          w_sof_now;
  logic [18:0]   w_cam_ptr_eff;
  logic [22:0]   w_cam_addr;
  logic [22:0]   w_vga_addr;
  logic [19:0]   w_cam_sum;
  logic [19:0]   w_vga_sum;
  logic          w_cam_wrap;
  logic          w_vga_wrap;

  // Requests are registered before arbitration, so a request seen at edge N
  // becomes a grant at edge N+1. This also means the requests sampled on the
  // edge that returns the FSM to IDLE are the first ones re-evaluated.
  assign w_vga_elig    = r_vga_req_q & r_frame_valid;
  assign w_cam_win     = r_cam_req_q & ((r_streak == STREAK_TOP) | ~w_vga_elig);
  assign w_grant       = (r_state == IDLE) & (w_cam_win | w_vga_elig);
  assign w_tmo         = (r_state == BUSY) & ~done & (r_tmo_cnt == TMO_LAST);
  assign w_burst_end   = (r_state == BUSY) & (done | w_tmo);
  assign w_cam_active  = (r_state != IDLE) & r_wr;
  assign w_sof_now     = cam_sof | r_sof_pend;

  // A start-of-frame arriving in the grant cycle must already steer the address.
  assign w_cam_ptr_eff = cam_sof ? '0 : r_cam_ptr;
  assign w_cam_addr    = (r_cam_bank ? BANK1_BASE : '0) + {4'b0000, w_cam_ptr_eff};
  assign w_vga_addr    = (r_vga_bank ? BANK1_BASE : '0) + {4'b0000, r_vga_ptr};
  assign w_cam_sum     = {1'b0, r_cam_ptr} + PTR_STEP;
  assign w_vga_sum     = {1'b0, r_vga_ptr} + PTR_STEP;
  assign w_cam_wrap    = (w_cam_sum == FRAME_END);
  assign w_vga_wrap    = (w_vga_sum == FRAME_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = ISSUE;
      ISSUE: begin
        w_go        = 1'b1;
        w_state_nxt = BUSY;
      end
      BUSY:    if (done || w_tmo) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cam_req_q   <= 1'b0;
      r_vga_req_q   <= 1'b0;
      r_wr          <= 1'b0;
      r_addr        <= '0;
      r_cam_bank    <= 1'b0;
      r_vga_bank    <= 1'b0;
      r_done_bank   <= 1'b0;
      r_cam_ptr     <= '0;
      r_vga_ptr     <= '0;
      r_frame_valid <= 1'b0;
      r_streak      <= '0;
      r_err         <= 1'b0;
      r_vga_rst     <= 1'b1;
      r_sof_pend    <= 1'b0;
      r_tmo_cnt     <= '0;
    end else begin
      r_cam_req_q <= cam_req;
      r_vga_req_q <= vga_req;

      if (r_frame_valid && !vga_req) r_vga_rst <= 1'b0;

      if (w_grant) begin
        if (w_cam_win) begin
          r_wr     <= 1'b1;
          r_addr   <= w_cam_addr;
          r_streak <= '0;
        end else begin
          r_wr   <= 1'b0;
          r_addr <= w_vga_addr;
          if (r_streak != STREAK_TOP) r_streak <= r_streak + 1'b1;
        end
      end

      if (r_state == ISSUE)     r_tmo_cnt <= '0;
      else if (r_state == BUSY) r_tmo_cnt <= r_tmo_cnt + 1'b1;

      if (w_tmo) r_err <= 1'b1;

      // Camera pointer: a start-of-frame during an active camera burst is held
      // until that burst ends, and then overrides any frame completion.
      if (w_cam_active) begin
        if (w_burst_end) begin
          r_sof_pend <= 1'b0;
          if (w_sof_now) begin
            r_cam_ptr <= '0;
          end else if (done) begin
            if (w_cam_wrap) begin
              r_cam_ptr     <= '0;
              r_done_bank   <= r_cam_bank;
              r_cam_bank    <= ~r_cam_bank;
              r_frame_valid <= 1'b1;
            end else begin
              r_cam_ptr <= w_cam_sum[18:0];
            end
          end
        end else if (cam_sof) begin
          r_sof_pend <= 1'b1;
        end
      end else if (cam_sof) begin
        r_cam_ptr <= '0;
      end

      if (w_burst_end && done && !r_wr) begin
        if (w_vga_wrap) begin
          r_vga_ptr  <= '0;
          r_vga_bank <= r_done_bank;
        end else begin
          r_vga_ptr <= w_vga_sum[18:0];
        end
      end
    end
  end

  assign go        = w_go;
  assign wr        = r_wr;
  assign brst_addr = r_addr;
  assign vga_rst   = r_vga_rst;
  assign cam_bank  = r_cam_bank;
  assign vga_bank  = r_vga_bank;
  assign err       = r_err;

endmodule

// File: tb/tb_psram_burst_scheduler.sv
// tb_psram_burst_scheduler
//   Acts as the PSRAM controller (returns done) and as the camera/VGA FIFOs.
//   A transaction-level model keeps frame pointers, banks and the arbitration
//   streak as plain integers and predicts each burst's direction and address.
module tb_psram_burst_scheduler;

  localparam int unsigned BL   = 16;
  localparam int unsigned FW   = 4352;
  localparam int unsigned SMAX = 4;
  localparam int unsigned TMO  = 1024;
  localparam logic [22:0] BASE = 23'h080000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cam_req;
  logic        vga_req;
  logic        cam_sof;
  logic        done;
  logic        go;
  logic        wr;
  logic [22:0] brst_addr;
  logic        vga_rst;
  logic        cam_bank;
  logic        vga_bank;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psram_burst_scheduler #(
    .BURST_LEN  (BL),
    .FRAME_WORDS(FW),
    .BANK1_BASE (BASE),
    .STREAK_MAX (SMAX),
    .TIMEOUT    (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cam_req  (cam_req),
    .vga_req  (vga_req),
    .cam_sof  (cam_sof),
    .done     (done),
    .go       (go),
    .wr       (wr),
    .brst_addr(brst_addr),
    .vga_rst  (vga_rst),
    .cam_bank (cam_bank),
    .vga_bank (vga_bank),
    .err      (err)
  );

  // Reference model state
  int m_cam_ptr, m_vga_ptr, m_streak;
  bit m_cam_bank, m_vga_bank, m_done_bank, m_fv, m_vrst;
  bit pend, pend_wr, pend_sof;

  typedef struct {
    bit          cr;
    bit          vr;
    int          delay;
    bit          exp_wr;
    logic [22:0] exp_addr;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cam_ptr = 0; m_vga_ptr = 0; m_streak = 0;
    m_cam_bank = 0; m_vga_bank = 0; m_done_bank = 0;
    m_fv = 0; m_vrst = 1; pend = 0; pend_wr = 0; pend_sof = 0;
  endtask

  task automatic model_done(input bit w, input bit s);
    if (w) begin
      if (s) m_cam_ptr = 0;
      else begin
        m_cam_ptr += BL;
        if (m_cam_ptr == FW) begin
          m_cam_ptr   = 0;
          m_done_bank = m_cam_bank;
          m_cam_bank  = ~m_cam_bank;
          m_fv        = 1;
        end
      end
    end else begin
      m_vga_ptr += BL;
      if (m_vga_ptr == FW) begin
        m_vga_ptr  = 0;
        m_vga_bank = m_done_bank;
      end
    end
  endtask

  function automatic logic [22:0] m_addr(input bit w);
    int a;
    if (w) a = (m_cam_bank ? int'(BASE) : 0) + m_cam_ptr;
    else   a = (m_vga_bank ? int'(BASE) : 0) + m_vga_ptr;
    return 23'(a);
  endfunction

  task automatic predict(input bit cr, input bit vr, output bit ew, output logic [22:0] ea);
    bit vel;
    vel = vr && m_fv;
    ew  = cr && (m_streak == SMAX || !vel);
    if (ew) m_streak = 0;
    else if (m_streak < SMAX) m_streak++;
    ea = m_addr(ew);
  endtask

  // One clock: apply the model effects of this edge, then compare level outputs.
  task automatic tick();
    if (m_fv && !vga_req) m_vrst = 0;
    if (pend) begin
      model_done(pend_wr, pend_sof);
      pend = 0;
    end
    @(posedge clk);
    #1;
    check("cam_bank", cam_bank, m_cam_bank);
    check("vga_bank", vga_bank, m_vga_bank);
    check("vga_rst", vga_rst, m_vrst);
  endtask

  task automatic wait_go(input bit cr, input bit vr, output bit found, output int lat);
    cam_req = cr;
    vga_req = vr;
    found = 0;
    lat = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      lat++;
      if (go === 1'b1) found = 1;
    end
    check("go_seen", found, 1);
  endtask

  task automatic finish_burst(input int delay, input bit sof, input bit hold,
                              input bit ew, input logic [22:0] ea);
    tick();
    check("go_width", go, 0);
    for (int i = 1; i < delay; i++) tick();
    check("wr_hold", wr, ew);
    check("addr_hold", brst_addr, ea);
    done = 1; cam_sof = sof;
    pend = 1; pend_wr = ew; pend_sof = sof;
    if (!hold) begin
      cam_req = 0;
      vga_req = 0;
    end
    tick();
    done = 0; cam_sof = 0;
  endtask

  task automatic burst(input bit cr, input bit vr, input int delay, input bit sof, input bit hold,
                       output bit ew, output logic [22:0] ea,
                       output bit gw, output logic [22:0] ga, output int lat);
    bit f;
    wait_go(cr, vr, f, lat);
    predict(cr, vr, ew, ea);
    gw = wr;
    ga = brst_addr;
    if (f) finish_burst(delay, sof && ew, hold, ew, ea);
    else begin
      cam_req = 0;
      vga_req = 0;
    end
  endtask

  task automatic mburst(input bit cr, input bit vr, input int delay, input bit sof, input bit hold);
    bit ew, gw;
    logic [22:0] ea, ga;
    int lat;
    burst(cr, vr, delay, sof, hold, ew, ea, gw, ga, lat);
    check("wr", gw, ew);
    check("addr", ga, ea);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ew, gw, f;
    logic [22:0] ea, ga, ea1;
    int lat, t, n;
    bit cr, vr, sof;

    for (int i = 0; i < 6; i++) begin
      tbl[i].cr = 1; tbl[i].vr = 1; tbl[i].delay = 20;
      tbl[i].exp_wr = 1; tbl[i].exp_addr = 23'(16 * i);
    end

    rst = 1; cam_req = 0; vga_req = 0; cam_sof = 0; done = 0;
    model_reset();
    tick(); tick();
    check("rst_go", go, 0);
    check("rst_wr", wr, 0);
    check("rst_addr", brst_addr, 0);
    check("rst_err", err, 0);
    check("rst_vga_rst", vga_rst, 1);
    rst = 0;
    tick();

    // Camera only eligible before the first frame; vga_req ignored.
    for (int i = 0; i < 6; i++) begin
      burst(tbl[i].cr, tbl[i].vr, tbl[i].delay, 0, 0, ew, ea, gw, ga, lat);
      check("tbl_wr", gw, tbl[i].exp_wr);
      check("tbl_addr", ga, tbl[i].exp_addr);
      check("tbl_latency", lat, 2);
    end

    // Finish the first frame.
    for (int i = 6; i < int'(FW / BL); i++) mburst(1, 0, 3, 0, 0);
    check("frame1_cam_bank", cam_bank, 1);
    check("vga_rst_before_fall", vga_rst, 1);
    tick();
    check("vga_rst_fall", vga_rst, 0);

    burst(1, 0, 3, 0, 0, ew, ea, gw, ga, lat);
    check("bank1_first_wr", gw, 1);
    check("bank1_first_addr", ga, 23'h080000);

    // Both requesting with the streak cleared: V,V,V,V,C repeating.
    for (int k = 0; k < 10; k++) begin
      burst(1, 1, 2, 0, (k < 9), ew, ea, gw, ga, lat);
      check("pattern_wr", gw, (k % 5 == 4));
      check("pattern_addr", ga, ea);
    end

    // Camera completes bank 1, then VGA reads to the end of its frame.
    n = 0;
    while (m_cam_bank == 1 && n < 400) begin mburst(1, 0, 2, 0, 0); n++; end
    check("bank1_done_cam_bank", cam_bank, 0);
    n = 0;
    while (m_vga_ptr != 0 && n < 400) begin mburst(0, 1, 2, 0, 0); n++; end
    check("vga_wrap_bank", vga_bank, 1);
    burst(0, 1, 2, 0, 0, ew, ea, gw, ga, lat);
    check("vga_wrap_wr", gw, 0);
    check("vga_wrap_addr", ga, 23'h080000);

    // Withheld done: timeout, err, same burst reissued.
    check("pre_tmo_err", err, 0);
    wait_go(1, 0, f, lat);
    predict(1, 0, ew, ea1);
    check("tmo_first_addr", brst_addr, ea1);
    t = 0;
    f = 0;
    while (t < int'(TMO) + 10 && !f) begin
      tick();
      t++;
      if (t == int'(TMO) - 1) check("tmo_err_early", err, 0);
      if (go === 1'b1) f = 1;
    end
    check("tmo_regrant", f, 1);
    check("tmo_gap_window", (t >= int'(TMO) + 1 && t <= int'(TMO) + 3), 1);
    check("tmo_err", err, 1);
    predict(1, 0, ew, ea);
    check("tmo_wr", wr, 1);
    check("tmo_same_addr", brst_addr, ea1);
    check("tmo_model_addr", brst_addr, ea);
    finish_burst(3, 0, 0, ew, ea);

    // Start-of-frame coincident with a camera done at cam_ptr = 4096.
    n = 0;
    while (m_cam_ptr != 4096 && n < 400) begin mburst(1, 0, 1, 0, 0); n++; end
    burst(1, 0, 3, 1, 0, ew, ea, gw, ga, lat);
    check("sof_burst_addr", ga, 23'd4096);
    check("sof_cam_bank", cam_bank, 0);
    burst(1, 0, 3, 0, 0, ew, ea, gw, ga, lat);
    check("sof_next_addr", ga, 23'd0);

    // Randomized traffic against the model, with stray done pulses in IDLE.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        done = 1;
        tick();
        done = 0;
      end
      cr  = 1'($urandom_range(0, 1));
      vr  = 1'($urandom_range(0, 1));
      if (!cr && !(vr && m_fv)) cr = 1;
      sof = ($urandom_range(0, 7) == 0);
      mburst(cr, vr, int'($urandom_range(1, 25)), sof, 0);
    end

    // Reset in BUSY abandons the burst.
    wait_go(1, 0, f, lat);
    predict(1, 0, ew, ea);
    tick(); tick();
    rst = 1;
    #1;
    check("busy_rst_go", go, 0);
    check("busy_rst_wr", wr, 0);
    check("busy_rst_addr", brst_addr, 0);
    check("busy_rst_cam_bank", cam_bank, 0);
    check("busy_rst_vga_bank", vga_bank, 0);
    check("busy_rst_vga_rst", vga_rst, 1);
    check("busy_rst_err", err, 0);
    model_reset();
    cam_req = 0;
    tick();
    rst = 0;
    tick();
    burst(1, 0, 2, 0, 0, ew, ea, gw, ga, lat);
    check("post_rst_wr", gw, 1);
    check("post_rst_addr", ga, 23'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
